// File: rtl/upsample_22_s2_pkg.sv
// Shared types and defaults for the 2x nearest-neighbour upsampler.
package upsample_22_s2_pkg;

  // Default frame side (input) and pixel width.
  localparam int DEFAULT_D          = 299;
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Output row being produced: first copy of an input row (PASS) or the
  // replay of that row out of the line buffer (REPLAY).
  typedef enum logic [0:0] {
    PASS   = 1'b0,
    REPLAY = 1'b1
  } state_t;

  // Within PASS, each input pixel is emitted twice: A on acceptance, B next.
  typedef enum logic [0:0] {
    PHASE_A = 1'b0,
    PHASE_B = 1'b1
  } phase_t;

  // Width of the col/rcnt/row counters: enough to count one output row.
  function automatic int cnt_width(input int side);
    return $clog2(2 * side);
  endfunction

endpackage

// File: rtl/upsample_22_s2_if.sv
// Pixel stream bundle: upstream pixel handshake in, upsampled stream out.
interface upsample_22_s2_if
  import upsample_22_s2_pkg::*;
#(
  parameter int data_width = DEFAULT_DATA_WIDTH
);

  logic                  valid_in;
  logic [data_width-1:0] pxl_in;
  logic                  in_ready;
  logic [data_width-1:0] pxl_out;
  logic                  valid_out;
  logic                  frame_done;

  // Producer side (drives input pixels, observes the output stream).
  modport master (
    output valid_in,
    output pxl_in,
    input  in_ready,
    input  pxl_out,
    input  valid_out,
    input  frame_done
  );

  // Upsampler side.
  modport slave (
    input  valid_in,
    input  pxl_in,
    output in_ready,
    output pxl_out,
    output valid_out,
    output frame_done
  );

endinterface

// File: rtl/upsample_22_s2_line_buffer_sp.sv
// Single-port line buffer holding one input row. Synchronous write and
// synchronous read with one cycle of read latency; a write cycle does not
// update the read data register.
module upsample_22_s2_line_buffer_sp
  import upsample_22_s2_pkg::*;
#(
  parameter int D          = DEFAULT_D,
  parameter int data_width = DEFAULT_DATA_WIDTH,
  parameter int ADDR_W     = $clog2(D)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem_r [0:D-1];
  logic [data_width-1:0] rdata_r;

  // Storage array write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read port, loaded only on read cycles.
  always_ff @(posedge clk) begin
    if (en && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/upsample_22_s2.sv
// 2x nearest-neighbour upsampler. Each accepted pixel is emitted twice on
// the first output row (PASS) and stored in a line buffer; the buffered row
// is then replayed with each pixel doubled (REPLAY). Output is registered and
// gap-free whenever the upstream keeps valid_in high.
module upsample_22_s2
  import upsample_22_s2_pkg::*;
#(
  parameter int D          = DEFAULT_D,
  parameter int data_width = DEFAULT_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  upsample_22_s2_if.slave  bus
);

  localparam int CNT_W  = cnt_width(D);
  localparam int ADDR_W = $clog2(D);

  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(D - 1);
  localparam logic [CNT_W-1:0] RCNT_LAST = CNT_W'(2 * D - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(D - 1);

  // Registered state.
  state_t                state_r;
  phase_t                phase_r;
  logic [CNT_W-1:0]      col_r;
  logic [CNT_W-1:0]      rcnt_r;
  logic [CNT_W-1:0]      row_r;
  logic [data_width-1:0] hold_r;
  logic [data_width-1:0] pxl_out_r;
  logic                  valid_out_r;
  logic                  frame_done_r;
  logic                  in_ready_r;

  // Next-state values.
  state_t                state_s;
  phase_t                phase_s;
  logic [CNT_W-1:0]      col_s;
  logic [CNT_W-1:0]      rcnt_s;
  logic [CNT_W-1:0]      row_s;
  logic [data_width-1:0] hold_s;
  logic [data_width-1:0] pxl_out_s;
  logic                  valid_out_s;
  logic                  frame_done_s;
  logic                  in_ready_s;

  // Line buffer port.
  logic                  buf_en_s;
  logic                  buf_we_s;
  logic [ADDR_W-1:0]     buf_addr_s;
  logic [data_width-1:0] buf_wdata_s;
  logic [data_width-1:0] buf_rdata_s;

  // Address of the pixel needed one REPLAY beat ahead: (rcnt + 1) >> 1.
  logic [ADDR_W-1:0]     rd_next_s;

  assign rd_next_s = rcnt_r[CNT_W-1:1] + ADDR_W'(rcnt_r[0]);

  upsample_22_s2_line_buffer_sp #(
    .D          (D),
    .data_width (data_width),
    .ADDR_W     (ADDR_W)
  ) u_line_buffer (
    .clk   (clk),
    .en    (buf_en_s),
    .we    (buf_we_s),
    .addr  (buf_addr_s),
    .wdata (buf_wdata_s),
    .rdata (buf_rdata_s)
  );

  // Next-state, counter, line-buffer and output decode for both row types.
  always_comb begin
    state_s      = state_r;
    phase_s      = phase_r;
    col_s        = col_r;
    rcnt_s       = rcnt_r;
    row_s        = row_r;
    hold_s       = hold_r;
    pxl_out_s    = pxl_out_r;
    valid_out_s  = 1'b0;
    frame_done_s = 1'b0;
    buf_en_s     = 1'b0;
    buf_we_s     = 1'b0;
    buf_addr_s   = col_r[ADDR_W-1:0];
    buf_wdata_s  = bus.pxl_in;

    case (state_r)
      PASS: begin
        case (phase_r)
          PHASE_A: begin
            if (bus.valid_in) begin
              // Accept: copy A goes straight out, pixel kept for copy B
              // and written to the line buffer for the replay row.
              hold_s      = bus.pxl_in;
              pxl_out_s   = bus.pxl_in;
              valid_out_s = 1'b1;
              buf_en_s    = 1'b1;
              buf_we_s    = 1'b1;
              phase_s     = PHASE_B;
            end else begin
              valid_out_s = 1'b0;
            end
          end
          PHASE_B: begin
            pxl_out_s   = hold_r;
            valid_out_s = 1'b1;
            phase_s     = PHASE_A;
            if (col_r == COL_LAST) begin
              // Row complete: prefetch column 0 so REPLAY starts bubble-free.
              col_s      = {CNT_W{1'b0}};
              state_s    = REPLAY;
              buf_en_s   = 1'b1;
              buf_addr_s = {ADDR_W{1'b0}};
            end else begin
              col_s = col_r + CNT_W'(1);
            end
          end
          default: begin
            phase_s = PHASE_A;
          end
        endcase
      end

      REPLAY: begin
        pxl_out_s   = buf_rdata_s;
        valid_out_s = 1'b1;
        if (rcnt_r == RCNT_LAST) begin
          rcnt_s       = {CNT_W{1'b0}};
          state_s      = PASS;
          phase_s      = PHASE_A;
          frame_done_s = (row_r == ROW_LAST);
          if (row_r == ROW_LAST) begin
            row_s = {CNT_W{1'b0}};
          end else begin
            row_s = row_r + CNT_W'(1);
          end
        end else begin
          rcnt_s     = rcnt_r + CNT_W'(1);
          buf_en_s   = 1'b1;
          buf_addr_s = rd_next_s;
        end
      end

      default: begin
        state_s = PASS;
        phase_s = PHASE_A;
      end
    endcase

    in_ready_s = (state_s == PASS) && (phase_s == PHASE_A);
  end

  // State, counters, hold and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= PASS;
      phase_r      <= PHASE_A;
      col_r        <= {CNT_W{1'b0}};
      rcnt_r       <= {CNT_W{1'b0}};
      row_r        <= {CNT_W{1'b0}};
      hold_r       <= {data_width{1'b0}};
      pxl_out_r    <= {data_width{1'b0}};
      valid_out_r  <= 1'b0;
      frame_done_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_s;
      phase_r      <= phase_s;
      col_r        <= col_s;
      rcnt_r       <= rcnt_s;
      row_r        <= row_s;
      hold_r       <= hold_s;
      pxl_out_r    <= pxl_out_s;
      valid_out_r  <= valid_out_s;
      frame_done_r <= frame_done_s;
      in_ready_r   <= in_ready_s;
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.pxl_out    = pxl_out_r;
  assign bus.valid_out  = valid_out_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_upsample_22_s2.sv
// Randomised scoreboard bench for upsample_22_s2 with a small frame (D=4).
// A reference model turns every accepted pixel into the expected output
// beats (data, frame_done, cycle); a separate monitor pops and compares.
module tb_upsample_22_s2;

  localparam int D_TB = 4;
  localparam int DW   = 32;

  typedef struct {
    logic [DW-1:0] px;
    logic          fd;
    int            cyc;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   errors;
  int   checks;
  int   fd_seen;

  exp_t          exp_q[$];
  logic [DW-1:0] row_px[$];
  int            row_idx;
  int            next_allowed;
  logic          post_reset;

  upsample_22_s2_if #(.data_width(DW)) bus_if ();

  upsample_22_s2 #(
    .D          (D_TB),
    .data_width (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
  end

  // Cycle index: value seen at a negedge labels the current cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  // Reference model: in_ready expectation and expected output beats.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      row_px.delete();
      row_idx      = 0;
      next_allowed = cyc + 1;
    end else begin
      logic exp_rdy;
      exp_rdy = (cyc >= next_allowed);
      checks++;
      if (bus_if.in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL in_ready cycle %0d: got %b expected %b", cyc, bus_if.in_ready, exp_rdy);
      end
      if (bus_if.valid_in && bus_if.in_ready) begin
        logic [DW-1:0] px;
        px = bus_if.pxl_in;
        exp_q.push_back('{px, 1'b0, cyc + 1});
        exp_q.push_back('{px, 1'b0, cyc + 2});
        row_px.push_back(px);
        next_allowed = cyc + 2;
        if (row_px.size() == D_TB) begin
          for (int k = 0; k < 2 * D_TB; k++) begin
            logic fd;
            fd = (row_idx == D_TB - 1) && (k == 2 * D_TB - 1);
            exp_q.push_back('{row_px[k / 2], fd, cyc + 3 + k});
          end
          next_allowed = cyc + 2 + 2 * D_TB;
          row_idx      = (row_idx + 1) % D_TB;
          row_px.delete();
        end
      end
    end
  end

  // Monitor: compares every presented output beat against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      post_reset = 1'b1;
    end else begin
      if (post_reset) begin
        checks++;
        if (bus_if.valid_out !== 1'b0 || bus_if.frame_done !== 1'b0 || bus_if.pxl_out !== '0) begin
          errors++;
          $display("FAIL reset_state cycle %0d: valid_out=%b frame_done=%b pxl_out=%h expected 0/0/0",
                   cyc, bus_if.valid_out, bus_if.frame_done, bus_if.pxl_out);
        end
        post_reset = 1'b0;
      end
      if (bus_if.valid_out === 1'b1) begin
        if (bus_if.frame_done === 1'b1) fd_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat cycle %0d: got pxl_out=%h, expected no output", cyc, bus_if.pxl_out);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus_if.pxl_out !== e.px || bus_if.frame_done !== e.fd || cyc != e.cyc) begin
            errors++;
            $display("FAIL beat: got pxl=%h fd=%b cycle=%0d, expected pxl=%h fd=%b cycle=%0d",
                     bus_if.pxl_out, bus_if.frame_done, cyc, e.px, e.fd, e.cyc);
          end
        end
      end else if (bus_if.frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL stray_frame_done cycle %0d: got %b expected 0", cyc, bus_if.frame_done);
      end
    end
  end

  // Present one pixel after an optional idle gap and wait for its transfer.
  task automatic send(input logic [DW-1:0] px, input int gap);
    logic got;
    if (gap > 0) begin
      bus_if.valid_in = 1'b0;
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    bus_if.valid_in = 1'b1;
    bus_if.pxl_in   = px;
    got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus_if.in_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: pixel %h not accepted within 200 cycles, expected acceptance", px);
    end
  endtask

  // Full frame of random pixels with optional random idle gaps.
  task automatic send_frame(input int max_gap);
    for (int i = 0; i < D_TB * D_TB; i++) begin
      send($urandom(), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    fd_seen         = 0;
    row_idx         = 0;
    next_allowed    = 0;
    post_reset      = 1'b0;
    reset           = 1'b1;
    bus_if.valid_in = 1'b0;
    bus_if.pxl_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Frame 1: row 1,2,3,4 with valid held high, then 99 held through REPLAY.
    send(32'd1, 0);
    send(32'd2, 0);
    send(32'd3, 0);
    send(32'd4, 0);
    send(32'd99, 0);
    for (int i = 0; i < D_TB * D_TB - 5; i++) send($urandom(), 0);

    // Frame 2 follows immediately; 3-cycle upstream gap before pixel 3.
    send($urandom(), 0);
    send($urandom(), 0);
    send($urandom(), 3);
    send($urandom(), 0);
    for (int i = 0; i < D_TB * D_TB - 4; i++) send($urandom(), int'($urandom_range(0, 2)));

    // Three rows, then reset in the middle of the third row's REPLAY.
    for (int i = 0; i < 3 * D_TB; i++) send($urandom(), 0);
    bus_if.valid_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fresh frames after the reset.
    send_frame(3);
    send_frame(0);

    bus_if.valid_in = 1'b0;
    repeat (4 * D_TB + 10) @(posedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still outstanding, expected 0", exp_q.size());
    end
    checks++;
    if (fd_seen != 4) begin
      errors++;
      $display("FAIL frame_done_count: got %0d expected 4", fd_seen);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
